// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer.
//  - seq_state_e : FSM state encoding. The numeric values appear on the
//                  seq_state status port, so they are fixed explicitly.
//  - *_CNT_W     : widths of the stable/hold/divider/loss counters.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } seq_state_e;

  localparam int STAB_CNT_W = 16;
  localparam int HOLD_CNT_W = 8;
  localparam int DIV_CNT_W  = 8;
  localparam int LOST_CNT_W = 8;

  localparam logic [LOST_CNT_W-1:0] LOST_MAX = '1;

endpackage

// File: rtl/clock_enable_divider.sv
// Clock-enable divider: emits one tick_out for every DIV tick_in pulses.
//  clk      in  clock
//  clear    in  holds the count at 0 and suppresses tick_out
//  tick_in  in  advance strobe
//  tick_out out combinational strobe, high with the DIV-th tick_in
// The parent registers tick_out, so two cascaded dividers produce
// coincident registered enables.
module clock_enable_divider
  import pll_seq_pkg::*;
#(
  parameter int DIV   = 12,
  parameter int WIDTH = DIV_CNT_W
) (
  input  logic clk,
  input  logic clear,
  input  logic tick_in,
  output logic tick_out
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DIV - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    tick_out = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick_in) begin
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        tick_out = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: no reset branch here; the parent asserts clear whenever the
  // sequencer is in reset or not running, which zeroes the count.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock supervisor and system bring-up sequencer.
//  clk         in   system clock (PLL-derived)
//  reset       in   synchronous active-high; returns to WAIT_LOCK
//  pll_lock    in   raw PLL lock flag, asynchronous to clk
//  sys_reset   out  active-high downstream reset, low only in RUN
//  ready       out  high only in RUN
//  cpu_en      out  one-cycle enable every CPU_DIV cycles in RUN
//  psg_en      out  one-cycle enable with every PSG_DIV-th cpu_en
//  lost_count  out  saturating count of lock-loss events
//  seq_state   out  current FSM state (debug/status)
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CPU_DIV            = 12,
  parameter int PSG_DIV            = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       sys_reset,
  output logic       ready,
  output logic       cpu_en,
  output logic       psg_en,
  output logic [7:0] lost_count,
  output logic [2:0] seq_state
);

  localparam logic [STAB_CNT_W-1:0] STAB_LAST = STAB_CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(RESET_HOLD_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic                   lock_meta_q, lock_meta_d;
  logic                   lock_s_q, lock_s_d;
  logic [STAB_CNT_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic [HOLD_CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [LOST_CNT_W-1:0]  lost_count_q, lost_count_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   ready_q, ready_d;
  logic                   cpu_en_q, cpu_en_d;
  logic                   psg_en_q, psg_en_d;
  logic                   div_clear;
  logic                   cpu_tick, psg_tick;

  // Dividers run only once the registered outputs show RUN, so the first
  // cpu_en lands CPU_DIV cycles after ready rises, and they stop the moment
  // the FSM leaves RUN so no enable accompanies a rising sys_reset.
  assign div_clear = reset || sys_reset_q || (state_q != ST_RUN);

  clock_enable_divider #(.DIV(CPU_DIV), .WIDTH(DIV_CNT_W)) u_cpu_div (
    .clk      (clk),
    .clear    (div_clear),
    .tick_in  (1'b1),
    .tick_out (cpu_tick)
  );

  clock_enable_divider #(.DIV(PSG_DIV), .WIDTH(DIV_CNT_W)) u_psg_div (
    .clk      (clk),
    .clear    (div_clear),
    .tick_in  (cpu_tick),
    .tick_out (psg_tick)
  );

  always_comb begin
    lock_meta_d  = pll_lock;
    lock_s_d     = lock_meta_q;
    state_d      = state_q;
    stab_cnt_d   = '0;
    hold_cnt_d   = '0;
    lost_count_d = lost_count_q;

    // Lock loss takes priority over counter completion in every state.
    unique case (state_q)
      ST_WAIT_LOCK: if (lock_s_q) state_d = ST_STABLE;
      ST_STABLE: begin
        if (!lock_s_q)                state_d = ST_WAIT_LOCK;
        else if (stab_cnt_q == STAB_LAST) state_d = ST_HOLD;
        else                          stab_cnt_d = stab_cnt_q + 1'b1;
      end
      ST_HOLD: begin
        if (!lock_s_q)                state_d = ST_LOST;
        else if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
        else                          hold_cnt_d = hold_cnt_q + 1'b1;
      end
      ST_RUN: if (!lock_s_q) state_d = ST_LOST;
      ST_LOST: begin
        state_d = ST_WAIT_LOCK;
        if (lost_count_q != LOST_MAX) lost_count_d = lost_count_q + 1'b1;
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    sys_reset_d = (state_q != ST_RUN);
    ready_d     = (state_q == ST_RUN);
    cpu_en_d    = cpu_tick;
    psg_en_d    = psg_tick;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_WAIT_LOCK;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      stab_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      lost_count_q <= '0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      cpu_en_q     <= 1'b0;
      psg_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_meta_q  <= lock_meta_d;
      lock_s_q     <= lock_s_d;
      stab_cnt_q   <= stab_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      lost_count_q <= lost_count_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      cpu_en_q     <= cpu_en_d;
      psg_en_q     <= psg_en_d;
    end
  end

  assign sys_reset  = sys_reset_q;
  assign ready      = ready_q;
  assign cpu_en     = cpu_en_q;
  assign psg_en     = psg_en_q;
  assign lost_count = lost_count_q;
  assign seq_state  = state_q;

endmodule
